// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core sequencer:
// opcodes, FSM state codes, control-word bit positions.
package sap_pkg;

    localparam logic [7:0] OP_LDA = 8'h00;
    localparam logic [7:0] OP_STA = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_JMP = 8'h08;
    localparam logic [7:0] OP_JZ  = 8'h09;
    localparam logic [7:0] OP_JC  = 8'h0A;
    localparam logic [7:0] OP_OUT = 8'h0B;
    localparam logic [7:0] OP_NOP = 8'h0E;
    localparam logic [7:0] OP_HLT = 8'h0F;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_EX1  = 4'd5,
        S_EX2  = 4'd6,
        S_HALT = 4'd7
    } state_e;

    localparam int CW_MAR_LD   = 0;
    localparam int CW_MAR_SRC  = 1;
    localparam int CW_PC_INC   = 2;
    localparam int CW_PC_LD    = 3;
    localparam int CW_IR_LD    = 4;
    localparam int CW_RAM_WE   = 5;
    localparam int CW_A_LD     = 6;
    localparam int CW_A_SRC    = 7;
    localparam int CW_ALU_SUB  = 8;
    localparam int CW_FLAGS_LD = 9;
    localparam int CW_OUT_LD   = 10;
    localparam int CW_DONE     = 11;
    localparam int CW_W        = 12;

    typedef struct packed {
        logic mem_rd;
        logic mem_wr;
        logic lda;
        logic sub;
        logic branch;
        logic jmp;
        logic jz;
        logic jc;
        logic out;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/sap_op_decode.sv
// Opcode classifier: maps the registered IR opcode
// onto the instruction classes the sequencer branches on.
module sap_op_decode
    import sap_pkg::*;
#(
    parameter int OPW = 8
) (
    input  logic [OPW-1:0] ir_op,
    output op_class_t      opc
);

    // one class per defined opcode, everything else is illegal
    always_comb begin
        opc = '0;
        unique case (1'b1)
            (ir_op == OPW'(OP_LDA)): begin
                opc.mem_rd = 1'b1;
                opc.lda    = 1'b1;
            end
            (ir_op == OPW'(OP_STA)): opc.mem_wr = 1'b1;
            (ir_op == OPW'(OP_ADD)): opc.mem_rd = 1'b1;
            (ir_op == OPW'(OP_SUB)): begin
                opc.mem_rd = 1'b1;
                opc.sub    = 1'b1;
            end
            (ir_op == OPW'(OP_JMP)): begin
                opc.branch = 1'b1;
                opc.jmp    = 1'b1;
            end
            (ir_op == OPW'(OP_JZ)): begin
                opc.branch = 1'b1;
                opc.jz     = 1'b1;
            end
            (ir_op == OPW'(OP_JC)): begin
                opc.branch = 1'b1;
                opc.jc     = 1'b1;
            end
            (ir_op == OPW'(OP_OUT)): opc.out  = 1'b1;
            (ir_op == OPW'(OP_NOP)): opc.nop  = 1'b1;
            (ir_op == OPW'(OP_HLT)): opc.halt = 1'b1;
            default:                 opc.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap_control_unit.sv
// SAP instruction sequencer: fetch/decode/execute FSM
// emitting one-hot datapath strobes, with run/step and sticky halt.
module sap_control_unit
    import sap_pkg::*;
#(
    parameter int OPW = 8,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           step,
    input  logic [OPW-1:0] ir_op,
    input  logic           flag_z,
    input  logic           flag_c,
    output logic           mar_ld,
    output logic           mar_src,
    output logic           pc_inc,
    output logic           pc_ld,
    output logic           ir_ld,
    output logic           ram_we,
    output logic           a_ld,
    output logic           a_src,
    output logic           alu_sub,
    output logic           flags_ld,
    output logic           out_ld,
    output logic           instr_done,
    output logic           halted,
    output logic           illegal,
    output logic [STW-1:0] state
);

    state_e          state_q, state_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    op_class_t       opc;
    logic [CW_W-1:0] cw;
    state_e          bnd_next;

    sap_op_decode #(.OPW(OPW)) u_dec (
        .ir_op (ir_op),
        .opc   (opc)
    );

    // where to go after the last cycle of an instruction
    always_comb begin
        bnd_next = run ? S_F0 : S_IDLE;
    end

    // next state, sticky status and strobes from current state + opcode
    always_comb begin
        state_d   = S_IDLE;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        cw        = '0;
        case (state_q)
            S_IDLE: state_d = (run || step) ? S_F0 : S_IDLE;
            S_F0: begin
                cw[CW_MAR_LD] = 1'b1;
                state_d       = S_F1;
            end
            S_F1: begin
                cw[CW_PC_INC] = 1'b1;
                state_d       = S_F2;
            end
            S_F2: begin
                cw[CW_IR_LD] = 1'b1;
                state_d      = S_DEC;
            end
            S_DEC: begin
                if (opc.mem_rd || opc.mem_wr) begin
                    cw[CW_MAR_LD]  = 1'b1;
                    cw[CW_MAR_SRC] = 1'b1;
                    state_d        = S_EX1;
                end else if (opc.halt || opc.illegal) begin
                    halted_d  = 1'b1;
                    illegal_d = illegal_q | opc.illegal;
                    state_d   = S_HALT;
                end else begin
                    cw[CW_PC_LD]  = opc.jmp
                                  | (opc.jz & flag_z)
                                  | (opc.jc & flag_c);
                    cw[CW_OUT_LD] = opc.out;
                    cw[CW_DONE]   = 1'b1;
                    state_d       = bnd_next;
                end
            end
            S_EX1: begin
                if (opc.mem_wr) begin
                    cw[CW_RAM_WE] = 1'b1;
                    cw[CW_DONE]   = 1'b1;
                    state_d       = bnd_next;
                end else begin
                    state_d = S_EX2;
                end
            end
            S_EX2: begin
                cw[CW_A_LD]     = 1'b1;
                cw[CW_A_SRC]    = ~opc.lda;
                cw[CW_FLAGS_LD] = ~opc.lda;
                cw[CW_ALU_SUB]  = opc.sub;
                cw[CW_DONE]     = 1'b1;
                state_d         = bnd_next;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // state register and sticky halt/illegal flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign mar_ld     = cw[CW_MAR_LD];
    assign mar_src    = cw[CW_MAR_SRC];
    assign pc_inc     = cw[CW_PC_INC];
    assign pc_ld      = cw[CW_PC_LD];
    assign ir_ld      = cw[CW_IR_LD];
    assign ram_we     = cw[CW_RAM_WE];
    assign a_ld       = cw[CW_A_LD];
    assign a_src      = cw[CW_A_SRC];
    assign alu_sub    = cw[CW_ALU_SUB];
    assign flags_ld   = cw[CW_FLAGS_LD];
    assign out_ld     = cw[CW_OUT_LD];
    assign instr_done = cw[CW_DONE];
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign state      = STW'(state_q);

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: behavioural SAP datapath around the
// sequencer, with queued expectations checked by a monitor.
module tb_sap_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  ir_op;
    logic        flag_z, flag_c;
    logic        mar_ld, mar_src, pc_inc, pc_ld, ir_ld, ram_we;
    logic        a_ld, a_src, alu_sub, flags_ld, out_ld;
    logic        instr_done, halted, illegal;
    logic [3:0]  state;

    always #5 clk = ~clk;

    sap_control_unit #(.OPW(8), .STW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .ir_op      (ir_op),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .mar_ld     (mar_ld),
        .mar_src    (mar_src),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .ir_ld      (ir_ld),
        .ram_we     (ram_we),
        .a_ld       (a_ld),
        .a_src      (a_src),
        .alu_sub    (alu_sub),
        .flags_ld   (flags_ld),
        .out_ld     (out_ld),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal    (illegal),
        .state      (state)
    );

    // ---------------- datapath model ----------------
    logic [15:0] prog [256];
    logic [15:0] ram  [256];
    logic [7:0]  pc, mar, pc_start;
    logic [15:0] ir, a, dout, outr;
    logic        z, c;
    logic [16:0] alu;
    logic [11:0] strb;

    assign alu    = alu_sub ? ({1'b0, a} - {1'b0, dout})
                            : ({1'b0, a} + {1'b0, dout});
    assign ir_op  = ir[15:8];
    assign flag_z = z;
    assign flag_c = c;
    assign strb   = {mar_ld, mar_src, pc_inc, pc_ld, ir_ld, ram_we,
                     a_ld, a_src, alu_sub, flags_ld, out_ld, instr_done};

    always @(posedge clk) begin
        if (rst) begin
            ram  <= prog;
            pc   <= pc_start;
            mar  <= 8'h00;
            ir   <= 16'h0000;
            a    <= 16'h0000;
            dout <= 16'h0000;
            outr <= 16'h0000;
            z    <= 1'b0;
            c    <= 1'b0;
        end else begin
            dout <= ram[mar];
            if (mar_ld) mar <= mar_src ? ir[7:0] : pc;
            if (pc_inc) pc <= pc + 8'd1;
            else if (pc_ld) pc <= ir[7:0];
            if (ir_ld) ir <= dout;
            if (ram_we) ram[mar] <= a;
            if (a_ld) a <= a_src ? alu[15:0] : dout;
            if (flags_ld) begin
                z <= (alu[15:0] == 16'h0000);
                c <= alu[16];
            end
            if (out_ld) outr <= a;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] op;
        int         cyc;
        bit         chk_pc;
        logic [7:0] pc;
    } done_t;

    done_t       done_q[$];
    int          out_q[$];
    int          sub_q[$];
    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          mem_seen = 1'b0;
    bit          pc_pend = 1'b0;
    logic [7:0]  pc_exp;

    function automatic void chk(string nm, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    function automatic void push_done(logic [7:0] op, int cy,
                                      bit cp, logic [7:0] pcv);
        done_t d;
        d.op     = op;
        d.cyc    = cy;
        d.chk_pc = cp;
        d.pc     = pcv;
        done_q.push_back(d);
    endfunction

    // monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        done_t d;
        if (rst) begin
            cyc      = 0;
            done_cnt = 0;
            mem_seen = 1'b0;
            pc_pend  = 1'b0;
        end else begin
            if (pc_pend) begin
                pc_pend = 1'b0;
                chk("pc_after_branch", int'(pc), int'(pc_exp));
            end
            if (mar_ld && !mar_src) cyc = 1;
            else cyc++;
            if (pc_inc && pc_ld) begin
                errs++;
                $display("FAIL pc_mutex: pc_inc=1 pc_ld=1");
            end
            if (ram_we && (a_ld || ir_ld)) begin
                errs++;
                $display("FAIL we_mutex: ram_we with a_ld/ir_ld");
            end
            if (ram_we || a_ld) mem_seen = 1'b1;
            if (out_ld) begin
                if (out_q.size() == 0) begin
                    errs++;
                    $display("FAIL out_extra: out_ld with A=%0d", a);
                end else begin
                    chk("out_val", int'(a), out_q.pop_front());
                end
            end
            if (flags_ld) begin
                if (sub_q.size() == 0) begin
                    errs++;
                    $display("FAIL flags_extra: flags_ld=1 want 0");
                end else begin
                    chk("alu_sub", int'(alu_sub), sub_q.pop_front());
                end
            end
            if (instr_done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    errs++;
                    $display("FAIL done_extra: op %0h got done want none",
                             ir_op);
                end else begin
                    d = done_q.pop_front();
                    chk("done_op", int'(ir_op), int'(d.op));
                    chk("done_cycles", cyc, d.cyc);
                    if (d.chk_pc) begin
                        pc_pend = 1'b1;
                        pc_exp  = d.pc;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(logic [7:0] start, logic run_v);
        @(negedge clk);
        rst      = 1'b1;
        run      = run_v;
        step     = 1'b0;
        pc_start = start;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(int n);
        for (int i = 0; i < n && !halted; i++) @(negedge clk);
    endtask

    logic [7:0] fib_op [9] = '{8'h00, 8'h0B, 8'h02, 8'h01, 8'h00,
                               8'h01, 8'h00, 8'h01, 8'h08};
    int fib_cy  [9] = '{6, 4, 6, 5, 6, 5, 6, 5, 4};
    int fib_out [9] = '{0, 1, 1, 2, 3, 5, 8, 13, 21};
    logic [15:0] fib_prog [9] = '{16'h0000, 16'h0B00, 16'h0201,
                                  16'h0102, 16'h0001, 16'h0100,
                                  16'h0002, 16'h0101, 16'h080A};

    initial begin
        int k;
        for (int i = 0; i < 256; i++) prog[i] = 16'h0E00;
        prog[0] = 16'h0000;
        prog[1] = 16'h0001;
        prog[2] = 16'h0000;
        for (int i = 0; i < 9; i++) prog[10 + i] = fib_prog[i];
        prog[8'h30] = 16'h0F00;
        prog[8'h38] = 16'h5500;
        prog[8'h50] = 16'h0920;
        prog[8'h51] = 16'h0360;
        prog[8'h52] = 16'h0920;
        prog[8'h60] = 16'h0000;
        prog[8'h20] = 16'h0F00;
        pc_start = 8'd10;

        // reset held 5 clocks with run=1, then Fibonacci
        rst = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_strobes", int'(strb), 0);
            chk("rst_status", int'({halted, illegal}), 0);
        end
        for (int i = 0; i < 9; i++) out_q.push_back(fib_out[i]);
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 9; j++)
                push_done(fib_op[j], fib_cy[j], j == 8, 8'd10);
            sub_q.push_back(0);
        end
        push_done(8'h00, 6, 1'b0, 8'h00);
        push_done(8'h0B, 4, 1'b0, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("first_mar_ld", int'({mar_ld, mar_src}), 2);
        k = 0;
        while (out_q.size() != 0 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("fib_outs_left", out_q.size(), 0);
        run = 1'b0;
        repeat (6) @(negedge clk);
        chk("fib_done_left", done_q.size(), 0);
        chk("fib_sub_left", sub_q.size(), 0);
        chk("fib_idle_strb", int'(strb), 0);
        chk("fib_stop_pc", int'(pc), 12);
        chk("fib_out_reg", int'(outr), 21);

        // HLT: sticky, run/step cannot restart it
        do_reset(8'h30, 1'b1);
        repeat (4) @(negedge clk);
        chk("hlt_not_yet", int'(halted), 0);
        @(negedge clk);
        chk("hlt_halted", int'(halted), 1);
        chk("hlt_illegal", int'(illegal), 0);
        for (int i = 0; i < 8; i++) begin
            run  = i[0];
            step = i[1];
            @(negedge clk);
            chk("hlt_quiet", int'(strb), 0);
            chk("hlt_sticky", int'(halted), 1);
        end

        // illegal opcode 0x55
        do_reset(8'h38, 1'b1);
        wait_halt(20);
        chk("ill_halted", int'(halted), 1);
        chk("ill_flag", int'(illegal), 1);
        repeat (3) @(negedge clk);
        chk("ill_no_mem", int'(mem_seen), 0);

        // single step: mid-instruction pulse ignored
        push_done(8'h0E, 4, 1'b1, 8'h41);
        push_done(8'h0E, 4, 1'b1, 8'h42);
        prog[8'h40] = 16'h0E00;
        prog[8'h41] = 16'h0E00;
        do_reset(8'h40, 1'b0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        chk("step_one", done_cnt, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (8) @(negedge clk);
        chk("step_dones", done_cnt, 2);
        chk("step_left", done_q.size(), 0);
        chk("step_idle", int'(strb), 0);

        // JZ not taken, SUB equal -> Z, JZ taken
        push_done(8'h09, 4, 1'b1, 8'h51);
        push_done(8'h03, 6, 1'b0, 8'h00);
        push_done(8'h09, 4, 1'b1, 8'h20);
        sub_q.push_back(1);
        do_reset(8'h50, 1'b1);
        wait_halt(60);
        chk("jz_halted", int'(halted), 1);
        chk("jz_illegal", int'(illegal), 0);
        chk("jz_done_left", done_q.size(), 0);
        chk("jz_sub_left", sub_q.size(), 0);
        chk("sub_zero", int'(z), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
